// File: rtl/ctrl_link_scheduler.sv
// ctrl_link_scheduler
//   Arbitrates between host commands and a periodic heartbeat, then runs one
//   transceiver transaction at a time: send, wait for tx done, wait for rx
//   good, with per-phase timeout and a bounded number of re-sends.
//
// Ports
//   sys_clk, rst          : clock, synchronous active-high reset
//   cmd_valid/cmd_data    : host command offer (128-bit package)
//   cmd_ready             : high only in IDLE when the command would be taken
//   hb_en/hb_data         : heartbeat enable and heartbeat package
//   xcvr_tx_package       : package held for the transceiver for the whole transaction
//   xcvr_tx_start         : one-cycle send strobe per attempt
//   xcvr_tx_done          : transceiver level status, only its rising edge counts
//   xcvr_rx_good          : transceiver level status, acknowledge received
//   busy                  : transaction in progress
//   done_pulse/done_src   : success strobe, source 0 = cmd, 1 = heartbeat
//   err_pulse/fail_cnt    : give-up strobe and saturating give-up counter
//   attempt_o             : attempt index of the current transaction
module ctrl_link_scheduler #(
  parameter int TIMEOUT_CYCLES = 200,
  parameter int MAX_RETRY      = 3,
  parameter int HB_PERIOD      = 10000
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         cmd_valid,
  input  logic [127:0] cmd_data,
  output logic         cmd_ready,
  input  logic         hb_en,
  input  logic [127:0] hb_data,
  output logic [127:0] xcvr_tx_package,
  output logic         xcvr_tx_start,
  input  logic         xcvr_tx_done,
  input  logic         xcvr_rx_good,
  output logic         busy,
  output logic         done_pulse,
  output logic         done_src,
  output logic         err_pulse,
  output logic [15:0]  fail_cnt,
  output logic [2:0]   attempt_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, ARM, WAIT_TX, WAIT_RX, FINISH
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [TW-1:0]   tcnt;
  logic [HW-1:0]   hb_cnt;
  logic            hb_pend;
  logic            prio_hb;      // 1: heartbeat wins the next tie
  logic            tx_done_prev;
  logic [2:0]      attempt_q;
  logic [127:0]    pkg_q;
  logic            src_q;

  logic            hb_win;
  logic            grant_cmd;
  logic            grant_hb;
  logic            tx_rise;
  logic            tmo;
  logic            hb_wrap;
  logic            attempt_fail;
  logic            retry;
  logic            give_up;

  // Heartbeat takes the slot when it is the only request, or on a tie when
  // the command source was granted last.
  assign hb_win    = hb_pend && (!cmd_valid || prio_hb);
  assign grant_hb  = (state == IDLE) && hb_win;
  assign grant_cmd = (state == IDLE) && cmd_valid && !hb_win;
  assign cmd_ready = (state == IDLE) && !hb_win;

  assign tx_rise = xcvr_tx_done && !tx_done_prev;
  assign tmo     = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign hb_wrap = hb_en && (hb_cnt == HW'(HB_PERIOD - 1));

  assign busy            = (state != IDLE);
  assign xcvr_tx_package = pkg_q;
  assign done_src        = src_q;
  assign attempt_o       = attempt_q;

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    attempt_fail  = 1'b0;
    retry         = 1'b0;
    give_up       = 1'b0;
    xcvr_tx_start = 1'b0;
    done_pulse    = 1'b0;
    case (state)
      IDLE:    if (grant_cmd || grant_hb) state_n = LOAD;
      LOAD:    state_n = START;
      START: begin
        xcvr_tx_start = 1'b1;
        state_n       = ARM;
      end
      // One blind cycle so status levels left over from the last
      // transaction cannot complete this one.
      ARM:     state_n = WAIT_TX;
      WAIT_TX: begin
        if (tx_rise)  state_n = WAIT_RX;
        else if (tmo) attempt_fail = 1'b1;
      end
      WAIT_RX: begin
        if (xcvr_rx_good) state_n = FINISH;
        else if (tmo)     attempt_fail = 1'b1;
      end
      FINISH: begin
        done_pulse = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (attempt_fail) begin
      if (attempt_q == 3'(MAX_RETRY)) begin
        give_up = 1'b1;
        state_n = IDLE;
      end else begin
        retry   = 1'b1;
        state_n = START;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      tcnt         <= '0;
      hb_cnt       <= '0;
      hb_pend      <= 1'b0;
      prio_hb      <= 1'b0;
      tx_done_prev <= 1'b0;
      attempt_q    <= 3'd0;
      fail_cnt     <= 16'd0;
      err_pulse    <= 1'b0;
      pkg_q        <= '0;
      src_q        <= 1'b0;
    end else begin
      tx_done_prev <= xcvr_tx_done;
      err_pulse    <= give_up;

      // Timeout counter restarts on every entry into a wait state.
      if ((state_n != state) || !((state == WAIT_TX) || (state == WAIT_RX)))
        tcnt <= '0;
      else
        tcnt <= tcnt + TW'(1);

      if (grant_cmd || grant_hb) begin
        pkg_q     <= grant_hb ? hb_data : cmd_data;
        src_q     <= grant_hb;
        prio_hb   <= grant_cmd;
        attempt_q <= 3'd0;
      end else if (state_n == IDLE) begin
        attempt_q <= 3'd0;
      end else if (retry) begin
        attempt_q <= attempt_q + 3'd1;
      end

      if (give_up && (fail_cnt != 16'hFFFF))
        fail_cnt <= fail_cnt + 16'd1;

      // A wrap while a heartbeat is already pending is absorbed.
      if (!hb_en) begin
        hb_cnt  <= '0;
        hb_pend <= 1'b0;
      end else begin
        hb_cnt <= hb_wrap ? '0 : hb_cnt + HW'(1);
        if (grant_hb)     hb_pend <= 1'b0;
        else if (hb_wrap) hb_pend <= 1'b1;
      end
    end
  end

endmodule
